serial_sub: RTL
===============

Name: serial_sub

Overview:
- Bit-serial ripple-borrow subtractor; the inverse counterpart of the team's combinational ripple-carry adder (RCA4).
- Computes D = A - B - bin over WIDTH clock cycles, LSB first, using one full-subtractor cell and shift registers.
- Uses a start/busy/done handshake so a controller or bench can issue operations back to back.
- Used as the area-cheap subtract path beside the parallel adder.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- D  output  WIDTH  difference; registered; valid while done=1 and held until the next accepted start.
- Bout  output  1  borrow-out of the MSB; registered; same validity as D.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking the edge where D/Bout become valid.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE; D=0, Bout=0, busy=0, done=0, ovf=0; shift registers and bit counter = 0.
- States:
  - IDLE: busy=0. If start=1 at an edge, capture A/B into shift registers and bin into the borrow flop, clear the counter, and go to RUN.
  - RUN: busy=1. Each edge processes bit i, LSB first:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - Shift d_i into the result register from the MSB side.
    - Counter increments.
  - RUN exit: on the edge processing bit WIDTH-1, load D with the full result and Bout with the final br', set done=1 for one cycle, and return to IDLE.
- Latency: if start is accepted at edge k, done=1 during the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy=1: ignored. Operands and result are not disturbed.
- start=1 in the cycle done=1: accepted, since the state is already IDLE. This gives one op per WIDTH+1 cycles. D/Bout still show the previous result in that cycle and update only at the new completion.
- A/B/bin changing after acceptance: no effect.
- rst asserted mid-RUN: operation aborted, all outputs 0, no done pulse.
- Arithmetic: unsigned modulo 2^WIDTH. Bout=1 iff A < B + bin as unsigned values.
- Boundary cases:
  - A = B with bin=0 gives D=0, Bout=0.
  - A=0, B=all-ones, bin=1 gives D=0, Bout=1 (full wrap).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port exists. ovf = (borrow into MSB) XOR Bout, i.e. the two's-complement signed overflow.
  - Registered with D; same validity and hold rules; reset to 0.
- Undefined: ovf port and its logic are absent; the rest of the behaviour is unchanged.

Test Plan (WIDTH=4):
- Reset then idle: hold rst=1 for 3 cycles, then release -> D=0000, Bout=0, busy=0, done=0; no done pulse without start.
- Basic op: start with A=0110, B=0111, bin=1 -> busy high for 4 cycles; done pulse at cycle 5 after the start edge; D=1110, Bout=1.
- Sequence of ops, each checked at done:
  - 1001-0101 bin=0 -> D=0100, Bout=0.
  - 0000-0001 bin=0 -> D=1111, Bout=1.
  - 1111-1111 bin=1 -> D=1111, Bout=1.
  - 1101-0001 bin=1 -> D=1011, Bout=0.
- Handshake corners:
  - Pulse start again mid-RUN with different operands -> ignored; result is that of the first op.
  - Assert start in the done cycle -> accepted; second result follows 5 cycles later.
- Reset mid-operation: assert rst during RUN cycle 2 of A=1011, B=1100 -> outputs 0 at once, no done pulse; the next op completes correctly.
- Overflow (SERIAL_SUB_OVF_EN):
  - 1000-0001 bin=0 -> D=0111, ovf=1, Bout=0.
  - 0111-1111 bin=0 -> D=1000, ovf=1, Bout=1.
  - 0110-0010 bin=0 -> D=0100, ovf=0.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor, D = A - B - bin, LSB first.
// One full-subtractor cell walks the operands over WIDTH cycles.
// start/busy/done handshake; D/Bout are held until the next completion.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
//
// state  | meaning
// S_IDLE | waiting for start; D/Bout hold the last result
// S_RUN  | one operand bit processed per clock, WIDTH clocks total
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             done,
  output logic             ovf
`else
  output logic             done
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  // Holds the WIDTH-1 most recent difference bits; the final bit is merged
  // directly into D on the last edge.
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    a_i     = a_sh[0];
    b_i     = b_sh[0];
    d_i     = a_i ^ b_i ^ br;
    br_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    res_nxt = {d_i, res_sh};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand shift registers, borrow flop and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      res_sh <= '0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= A;
      b_sh   <= B;
      br     <= bin;
      res_sh <= '0;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= br_nxt;
      res_sh <= res_nxt[WIDTH-1:1];
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers: loaded only on the final bit, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        D    <= res_nxt;
        Bout <= br_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= br ^ br_nxt;
    end
  end
`endif

endmodule
